// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-macro signals of the unified memory port arbiter.
// Latency: none, wires only.
// Backpressure: none; requesters hold req until their done pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch requester
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [DATA_WIDTH-1:0] if_rdata;

    // data requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_done;
    logic [DATA_WIDTH-1:0] d_rdata;

    // memory macro
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    // environment side: requesters plus the memory read data return
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

    // arbiter side
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_done, if_rdata, d_done, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters, round-robin on conflict.
// Latency: request seen in IDLE at cycle N -> done pulse at N + MEM_LATENCY + 2, fixed.
// Backpressure: one access outstanding; requests are only looked at in IDLE, losers keep req high.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // down-counter width covers the legal latency range 1..15
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t                state,       state_nxt;
    owner_t                owner,       owner_nxt;
    owner_t                last_gnt,    last_gnt_nxt;
    owner_t                owner_sel;
    logic [3:0]            cnt,         cnt_nxt;

    logic                  mem_en_q,    mem_en_nxt;
    logic                  mem_we_q,    mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_nxt;
    logic                  if_done_q,   if_done_nxt;
    logic                  d_done_q,    d_done_nxt;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_nxt;
    logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_nxt;
    logic                  busy_q,      busy_nxt;

    // next state and next values of every registered output
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_gnt_nxt  = last_gnt;
        owner_sel     = OWN_IF;
        cnt_nxt       = cnt;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        if_done_nxt   = 1'b0;
        d_done_nxt    = 1'b0;
        if_rdata_nxt  = if_rdata_q;
        d_rdata_nxt   = d_rdata_q;

        case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // on conflict the requester that did not win last time goes first
                    if (bus.if_req && bus.d_req) begin
                        owner_sel = (last_gnt == OWN_IF) ? OWN_D : OWN_IF;
                    end else if (bus.d_req) begin
                        owner_sel = OWN_D;
                    end else begin
                        owner_sel = OWN_IF;
                    end
                    owner_nxt    = owner_sel;
                    last_gnt_nxt = owner_sel;
                    mem_en_nxt   = 1'b1;
                    state_nxt    = ISSUE;
                    if (owner_sel == OWN_D) begin
                        mem_addr_nxt  = bus.d_addr;
                        mem_we_nxt    = bus.d_we;
                        mem_wdata_nxt = bus.d_wdata;
                    end else begin
                        // fetches never write; wdata keeps its previous value
                        mem_addr_nxt  = bus.if_addr;
                        mem_we_nxt    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                cnt_nxt   = LAT;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    // read data is valid in this cycle; stores leave d_rdata alone
                    if (owner == OWN_IF) begin
                        if_rdata_nxt = bus.mem_rdata;
                        if_done_nxt  = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_nxt = bus.mem_rdata;
                        end
                        d_done_nxt = 1'b1;
                    end
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // state and output registers; reset abandons any in-flight access without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            last_gnt    <= OWN_IF;
            cnt         <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_gnt    <= last_gnt_nxt;
            cnt         <= cnt_nxt;
            mem_en_q    <= mem_en_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            if_done_q   <= if_done_nxt;
            d_done_q    <= d_done_nxt;
            if_rdata_q  <= if_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
            busy_q      <= busy_nxt;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vectors, conflict sequences, latency corners, random traffic.
// Latency: checks done at request cycle + MEM_LATENCY + 2.
// Backpressure: requesters hold req until done and drop it on the following edge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    int   cyc;
    int   checks;
    int   errors;

    always #5 clk = ~clk;

    // cycle index: inside cycle N (between edges) cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m2  ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1  ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m15 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2))  dut2  (.clk(clk), .rst(rst), .bus(m2.slave));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1))  dut1  (.clk(clk), .rst(rst), .bus(m1.slave));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(15)) dut15 (.clk(clk), .rst(rst), .bus(m15.slave));

    // ---------------- memory models ----------------
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h10)       return 32'h0050_0093;
        else if (a == 32'h200) return 32'h1234_5678;
        else                   return {16'hA5C3, a[15:0]};
    endfunction

    logic [31:0] mem_dat [0:1023];
    logic        mem_wr  [0:1023];
    logic        pv [0:2][1:15];
    logic [31:0] pd [0:2][1:15];
    logic [2:0]  rd_en;
    logic [31:0] rd_ad [0:2];
    logic [31:0] junk;

    function automatic logic [31:0] main_read(input logic [31:0] a);
        if (mem_wr[a[11:2]] === 1'b1) return mem_dat[a[11:2]];
        return init_word(a);
    endfunction

    assign rd_en[0] = m2.mem_en  && !m2.mem_we;
    assign rd_en[1] = m1.mem_en  && !m1.mem_we;
    assign rd_en[2] = m15.mem_en && !m15.mem_we;
    assign rd_ad[0] = m2.mem_addr;
    assign rd_ad[1] = m1.mem_addr;
    assign rd_ad[2] = m15.mem_addr;
    assign junk     = 32'hBAD0_0000 ^ 32'(cyc);

    // read data appears only in the exact cycle it is due, junk otherwise
    assign m2.mem_rdata  = (pv[0][2]  === 1'b1) ? pd[0][2]  : junk;
    assign m1.mem_rdata  = (pv[1][1]  === 1'b1) ? pd[1][1]  : junk;
    assign m15.mem_rdata = (pv[2][15] === 1'b1) ? pd[2][15] : junk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem_wr[i] <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int k = 1; k <= 15; k++) pv[i][k] <= 1'b0;
        end else begin
            if (m2.mem_en && m2.mem_we) begin
                mem_wr[m2.mem_addr[11:2]]  <= 1'b1;
                mem_dat[m2.mem_addr[11:2]] <= m2.mem_wdata;
            end
            for (int i = 0; i < 3; i++) begin
                for (int k = 15; k >= 2; k--) begin
                    pv[i][k] <= pv[i][k-1];
                    pd[i][k] <= pd[i][k-1];
                end
                pv[i][1] <= rd_en[i];
                pd[i][1] <= (i == 0) ? main_read(rd_ad[i]) : init_word(rd_ad[i]);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;   // owner's rdata after done (held value for stores)
    } vec_t;

    // one access on the latency-2 instance, no competing request
    task automatic single(input vec_t v);
        int   n, en_cnt, done_at, odone;
        logic drop;
        @(posedge clk); #1;
        if (v.is_d) begin
            m2.d_req = 1'b1; m2.d_we = v.we; m2.d_addr = v.addr; m2.d_wdata = v.wdata;
        end else begin
            m2.if_req = 1'b1; m2.if_addr = v.addr;
        end
        n = cyc; en_cnt = 0; done_at = -1; odone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drop = 1'b0;
            if (m2.mem_en) begin
                en_cnt++;
                chk("issue_cycle", 32'(cyc - n), 32'd1);
                chk("mem_addr", m2.mem_addr, v.addr);
                chk("mem_we", 32'(m2.mem_we), 32'(v.is_d & v.we));
                if (v.is_d && v.we) chk("mem_wdata", m2.mem_wdata, v.wdata);
            end
            if (k >= 1 && k <= 3) chk("busy", 32'(m2.busy), 32'd1);
            if (v.is_d ? m2.d_done : m2.if_done) begin
                done_at = cyc;
                drop    = 1'b1;
                chk("rdata_at_done", v.is_d ? m2.d_rdata : m2.if_rdata, v.exp_rdata);
            end
            if (v.is_d ? m2.if_done : m2.d_done) odone++;
            @(posedge clk); #1;
            if (drop) begin m2.if_req = 1'b0; m2.d_req = 1'b0; end
        end
        chk("mem_en_count", 32'(en_cnt), 32'd1);
        chk("done_latency", 32'(done_at - n), 32'd4);
        chk("other_done", 32'(odone), 32'd0);
        chk("busy_idle", 32'(m2.busy), 32'd0);
        chk("rdata_held", v.is_d ? m2.d_rdata : m2.if_rdata, v.exp_rdata);
    endtask

    // both requesters rise in the same cycle
    task automatic pair(input string tag, input logic [31:0] ia, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input logic d_first,
                        input logic [31:0] exp_if, input logic [31:0] exp_d);
        int   n, if_at, d_at, en_cnt, both;
        logic drop_if, drop_d;
        @(posedge clk); #1;
        m2.if_req = 1'b1; m2.if_addr = ia;
        m2.d_req = 1'b1; m2.d_we = dwe; m2.d_addr = da; m2.d_wdata = dwd;
        n = cyc; if_at = -1; d_at = -1; en_cnt = 0; both = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drop_if = 1'b0; drop_d = 1'b0;
            if (m2.mem_en) begin
                en_cnt++;
                chk({tag, "_mem_addr"}, m2.mem_addr, ((en_cnt == 1) == d_first) ? da : ia);
            end
            if (m2.if_done && m2.d_done) both++;
            if (m2.if_done) begin
                if_at = cyc; drop_if = 1'b1;
                chk({tag, "_if_rdata"}, m2.if_rdata, exp_if);
            end
            if (m2.d_done) begin
                d_at = cyc; drop_d = 1'b1;
                if (!dwe) chk({tag, "_d_rdata"}, m2.d_rdata, exp_d);
            end
            @(posedge clk); #1;
            if (drop_if) m2.if_req = 1'b0;
            if (drop_d)  m2.d_req  = 1'b0;
        end
        chk({tag, "_d_done_cycle"},  32'(d_at - n),  d_first ? 32'd4 : 32'd9);
        chk({tag, "_if_done_cycle"}, 32'(if_at - n), d_first ? 32'd9 : 32'd4);
        chk({tag, "_mem_en_count"},  32'(en_cnt), 32'd2);
        chk({tag, "_both_done"},     32'(both), 32'd0);
    endtask

    // random-phase reference memory (region 0x800..0xFFC only)
    logic [31:0] ref_dat [0:1023];
    logic        ref_wr  [0:1023];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_wr[a[11:2]]) return ref_dat[a[11:2]];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'h800 + 32'($urandom_range(0, 511)) * 32'd4;
    endfunction

    vec_t tbl [6];

    initial begin
        int   n, at1, at15, en1, en15, c;
        logic d1, d15, drop;
        // reference model state
        int   free_at, exp_if_cyc, exp_d_cyc, exp_en_cyc, i_cool, d_cool;
        logic last_d, pick_d, done_if, done_d;
        logic [31:0] exp_if_dat, exp_d_dat, exp_if_rd, exp_d_rd;
        logic [31:0] exp_en_addr, exp_en_wdata;
        logic        exp_en_we;

        checks = 0; errors = 0;
        tbl[0] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[1] = '{1'b0, 1'b0, 32'h010, 32'h0,         32'h0050_0093};
        tbl[2] = '{1'b1, 1'b0, 32'h200, 32'h0,         32'h1234_5678};
        tbl[3] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 1'b0, 32'h024, 32'h0,         32'hA5C3_0024};
        tbl[5] = '{1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 32'hDEAD_BEEF};

        rst = 1'b1; mem_clr = 1'b1;
        m2.if_req = 0;  m2.if_addr = 0;  m2.d_req = 0;  m2.d_we = 0;  m2.d_addr = 0;  m2.d_wdata = 0;
        m1.if_req = 0;  m1.if_addr = 0;  m1.d_req = 0;  m1.d_we = 0;  m1.d_addr = 0;  m1.d_wdata = 0;
        m15.if_req = 0; m15.if_addr = 0; m15.d_req = 0; m15.d_we = 0; m15.d_addr = 0; m15.d_wdata = 0;
        repeat (3) @(posedge clk);
        #1 mem_clr = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_if_done",   32'(m2.if_done), 32'd0);
        chk("rst_d_done",    32'(m2.d_done),  32'd0);
        chk("rst_if_rdata",  m2.if_rdata,     32'd0);
        chk("rst_d_rdata",   m2.d_rdata,      32'd0);
        chk("rst_mem_en",    32'(m2.mem_en),  32'd0);
        chk("rst_mem_we",    32'(m2.mem_we),  32'd0);
        chk("rst_mem_addr",  m2.mem_addr,     32'd0);
        chk("rst_mem_wdata", m2.mem_wdata,    32'd0);
        chk("rst_busy",      32'(m2.busy),    32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // directed single accesses
        for (int i = 0; i < 6; i++) single(tbl[i]);

        // conflict right after reset: D first, then IF
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        pair("conflict1", 32'h10, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0050_0093, 32'h1234_5678);
        // a D access makes D the last grant, so the next conflict serves IF first
        single('{1'b1, 1'b1, 32'h108, 32'h0BAD_F00D, 32'h1234_5678});
        pair("conflict2", 32'h104, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE_F00D, 32'h0050_0093);

        // reset in the middle of WAIT
        @(posedge clk); #1;
        m2.if_req = 1'b1; m2.if_addr = 32'h24;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",     32'(m2.busy),   32'd0);
        chk("arst_mem_addr", m2.mem_addr,    32'd0);
        chk("arst_if_rdata", m2.if_rdata,    32'd0);
        chk("arst_d_rdata",  m2.d_rdata,     32'd0);
        chk("arst_mem_en",   32'(m2.mem_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_no_done", 32'(m2.if_done | m2.d_done), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        n = cyc; at1 = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drop = 1'b0;
            if (m2.if_done) begin
                at1 = cyc; drop = 1'b1;
                chk("post_rst_rdata", m2.if_rdata, 32'hA5C3_0024);
            end
            @(posedge clk); #1;
            if (drop) m2.if_req = 1'b0;
        end
        chk("post_rst_latency", 32'(at1 - n), 32'd4);

        // latency corners
        @(posedge clk); #1;
        m1.if_req = 1'b1; m1.if_addr = 32'h10;
        m15.if_req = 1'b1; m15.if_addr = 32'h10;
        n = cyc; at1 = -1; at15 = -1; en1 = 0; en15 = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            d1 = 1'b0; d15 = 1'b0;
            if (m1.mem_en)  en1++;
            if (m15.mem_en) en15++;
            if (m1.if_done) begin
                at1 = cyc; d1 = 1'b1;
                chk("lat1_rdata", m1.if_rdata, 32'h0050_0093);
            end
            if (m15.if_done) begin
                at15 = cyc; d15 = 1'b1;
                chk("lat15_rdata", m15.if_rdata, 32'h0050_0093);
            end
            @(posedge clk); #1;
            if (d1)  m1.if_req  = 1'b0;
            if (d15) m15.if_req = 1'b0;
        end
        chk("lat1_done_cycle",  32'(at1 - n),  32'd3);
        chk("lat15_done_cycle", 32'(at15 - n), 32'd17);
        chk("lat1_mem_en",      32'(en1),      32'd1);
        chk("lat15_mem_en",     32'(en15),     32'd1);

        // random traffic against a transaction-level model
        for (int i = 0; i < 1024; i++) ref_wr[i] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        free_at = cyc; last_d = 1'b0;
        exp_if_cyc = -1; exp_d_cyc = -1; exp_en_cyc = -1;
        exp_if_rd = 0; exp_d_rd = 0; exp_if_dat = 0; exp_d_dat = 0;
        exp_en_addr = 0; exp_en_we = 0; exp_en_wdata = 0;
        i_cool = 0; d_cool = 0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            c = cyc;
            if (c == exp_if_cyc) exp_if_rd = exp_if_dat;
            if (c == exp_d_cyc)  exp_d_rd  = exp_d_dat;
            chk("rnd_if_done", 32'(m2.if_done), 32'(c == exp_if_cyc));
            chk("rnd_d_done",  32'(m2.d_done),  32'(c == exp_d_cyc));
            chk("rnd_mem_en",  32'(m2.mem_en),  32'(c == exp_en_cyc));
            if (c == exp_if_cyc) chk("rnd_if_rdata", m2.if_rdata, exp_if_rd);
            if (c == exp_d_cyc)  chk("rnd_d_rdata",  m2.d_rdata,  exp_d_rd);
            if (c == exp_en_cyc) begin
                chk("rnd_mem_addr", m2.mem_addr, exp_en_addr);
                chk("rnd_mem_we", 32'(m2.mem_we), 32'(exp_en_we));
                if (exp_en_we) chk("rnd_mem_wdata", m2.mem_wdata, exp_en_wdata);
            end
            done_if = m2.if_done;
            done_d  = m2.d_done;
            // arbiter is free from free_at on; the pending requester not granted last time wins
            if (c >= free_at && (m2.if_req || m2.d_req)) begin
                pick_d     = m2.d_req && (!m2.if_req || !last_d);
                last_d     = pick_d;
                exp_en_cyc = c + 1;
                free_at    = c + 2 + 3;
                if (pick_d) begin
                    exp_d_cyc    = c + 4;
                    exp_en_addr  = m2.d_addr;
                    exp_en_we    = m2.d_we;
                    exp_en_wdata = m2.d_wdata;
                    if (m2.d_we) begin
                        ref_wr[m2.d_addr[11:2]]  = 1'b1;
                        ref_dat[m2.d_addr[11:2]] = m2.d_wdata;
                        exp_d_dat = exp_d_rd;
                    end else begin
                        exp_d_dat = ref_read(m2.d_addr);
                    end
                end else begin
                    exp_if_cyc  = c + 4;
                    exp_en_addr = m2.if_addr;
                    exp_en_we   = 1'b0;
                    exp_if_dat  = ref_read(m2.if_addr);
                end
            end
            @(posedge clk); #1;
            if (done_if) begin
                m2.if_req = 1'b0; i_cool = $urandom_range(0, 3);
            end else if (!m2.if_req) begin
                if (i_cool > 0) i_cool--;
                else if ($urandom_range(0, 1) == 1) begin
                    m2.if_req = 1'b1; m2.if_addr = rnd_addr();
                end
            end
            if (done_d) begin
                m2.d_req = 1'b0; d_cool = $urandom_range(0, 3);
            end else if (!m2.d_req) begin
                if (d_cool > 0) d_cool--;
                else if ($urandom_range(0, 1) == 1) begin
                    m2.d_req = 1'b1; m2.d_we = 1'($urandom_range(0, 1));
                    m2.d_addr = rnd_addr(); m2.d_wdata = $urandom;
                end
            end
        end
        m2.if_req = 1'b0; m2.d_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Round-robin arbitration on conflict. Sequences each access through a fixed-latency issue/wait/complete FSM.
- Returns read data and a one-cycle done pulse to the winning requester.
- Sits between fetch_top/memory_top and the memory macro; the CPU stalls on the requester's pending request until its done pulse.

Parameters:
- ADDR_WIDTH, 32, byte address width of both requesters and the memory.
- DATA_WIDTH, 32, data word width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- if_req  input  1  fetch read request, held high until if_done.
- if_addr  input  ADDR_WIDTH  fetch address, stable while if_req is high.
- if_done  output  1  one-cycle pulse: fetch access complete, if_rdata valid.
- if_rdata  output  DATA_WIDTH  fetched instruction word.
- d_req  input  1  data request, held high until d_done.
- d_we  input  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  input  ADDR_WIDTH  data address.
- d_wdata  input  DATA_WIDTH  store data.
- d_done  output  1  one-cycle pulse: data access complete; d_rdata valid on loads.
- d_rdata  output  DATA_WIDTH  load data.
- mem_en  output  1  memory access strobe, one cycle per access.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any state):
  - state = IDLE, owner = IF, last_gnt = IF, cnt = 0.
  - All outputs 0, including if_rdata and d_rdata.
  - An in-flight access is abandoned and no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - Only if_req: owner = IF.
  - Only d_req: owner = D.
  - Both: owner = the requester not equal to last_gnt. After reset this grants D first.
  - Any request: latch address, we (0 for IF) and wdata into mem_* registers; set last_gnt = owner; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_en = 1 for exactly this cycle; cnt loaded with MEM_LATENCY; go to WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt reaches 1, sample mem_rdata into the owner's rdata register (loads and fetches only). Store accesses leave d_rdata unchanged.
  - Then go to DONE.
- DONE: owner's done = 1 for exactly this cycle; go to IDLE.
- Latency: request seen in IDLE at cycle N gives done at cycle N + MEM_LATENCY + 2. Fixed; no early completion.
- Outside ISSUE: mem_en = 0. mem_addr, mem_we and mem_wdata hold their last values.
- Request hand-off:
  - The requester drops req on the edge after done.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
  - The other requester, if waiting, wins that IDLE cycle by round-robin.
- Request inputs are ignored outside IDLE. A req rising mid-transaction waits for IDLE.
- A request dropped before done is a protocol violation; the transaction still completes.
- if_rdata/d_rdata hold their values until overwritten by the next completion for that port.
- Never both dones in the same cycle; at most one access outstanding.

Test Plan:
- Single fetch: MEM_LATENCY = 2, if_req = 1, if_addr = 0x0000_0010, memory returns 0x0050_0093 → mem_en pulses once with mem_we = 0 and addr 0x10; if_done at N+4 with if_rdata = 0x0050_0093; busy high N+1..N+3.
- Store: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF → mem_en & mem_we one cycle with those values; d_done at N+4; d_rdata unchanged (0).
- Conflict after reset: if_req and d_req both rise at cycle N → D served first (d_done N+4). IF is granted in the next IDLE (N+5) and gets if_done at N+9. A second simultaneous conflict grants IF then D.
- Load: d_req = 1, d_we = 0, addr 0x200, mem_rdata = 0x1234_5678 at the sample cycle → d_rdata = 0x1234_5678 with d_done; if_done stays 0.
- MEM_LATENCY = 1 and MEM_LATENCY = 15: single fetch → done at N+3 and N+17 respectively; exactly one mem_en per access.
- Reset mid-operation: assert rst during WAIT → outputs 0 immediately (asynchronously), no done pulse. After release with if_req held, a fresh access starts and completes normally.
